// File: rtl/board_engine_pkg.sv
// Shared types for board_engine: result codes, FSM states, scan directions.
// Build option: BOARD_ENGINE_EARLY_EXIT_EN (see board_engine.sv).
package board_pkg;

   typedef enum logic [1:0] {
      NONE   = 2'b00,
      X_WINS = 2'b01,
      O_WINS = 2'b10,
      DRAW   = 2'b11
   } result_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      DIR_H,
      DIR_V,
      DIR_D,
      DIR_A
   } dir_t;

endpackage

// File: rtl/board_engine_if.sv
// Move request handshake between the move source and board_engine.
interface board_engine_if #(
   parameter int N = 3
);
   localparam int RW = $clog2(N);

   logic          move_valid;
   logic          move_ready;
   logic [RW-1:0] move_row;
   logic [RW-1:0] move_col;
   logic          move_err;

   modport master (
      output move_valid, move_row, move_col,
      input  move_ready, move_err
   );

   modport slave (
      input  move_valid, move_row, move_col,
      output move_ready, move_err
   );
endinterface

// File: rtl/board_engine_line_counter.sv
// Combinational run-length of one player's marks through a cell along one direction.
module line_counter
   import board_pkg::*;
#(
   parameter  int N  = 3,
   parameter  int K  = 3,
   localparam int RW = $clog2(N),
   localparam int IW = $clog2(N*N),
   localparam int CW = $clog2(K+1)
) (
   input  logic [N*N-1:0] i_plane,
   input  logic [RW-1:0]  i_row,
   input  logic [RW-1:0]  i_col,
   input  dir_t           i_dir,
   output logic [CW-1:0]  o_run
);

   always_comb begin : scan
      int dr, dc, r, c, cnt;
      logic fwd, bwd;
      logic [IW-1:0] ix;
      dr  = 0;
      dc  = 1;
      cnt = 1;
      fwd = 1'b1;
      bwd = 1'b1;
      ix  = '0;
      case (i_dir)
         DIR_V:   begin dr = 1; dc = 0;  end
         DIR_D:   begin dr = 1; dc = 1;  end
         DIR_A:   begin dr = 1; dc = -1; end
         default: begin dr = 0; dc = 1;  end
      endcase
      // walk outward both ways; a gap or board edge stops that side
      for (int s = 1; s < K; s++) begin
         r  = int'(i_row) + s*dr;
         c  = int'(i_col) + s*dc;
         ix = IW'(r*N + c);
         if (fwd && r >= 0 && r < N && c >= 0 && c < N && i_plane[ix])
            cnt = cnt + 1;
         else
            fwd = 1'b0;
         r  = int'(i_row) - s*dr;
         c  = int'(i_col) - s*dc;
         ix = IW'(r*N + c);
         if (bwd && r >= 0 && r < N && c >= 0 && c < N && i_plane[ix])
            cnt = cnt + 1;
         else
            bwd = 1'b0;
      end
      o_run = (cnt >= K) ? CW'(K) : CW'(cnt);
   end

endmodule

// File: rtl/board_engine.sv
// N x N, K-in-a-row game engine with sequential four-direction win scan.
// Build option: BOARD_ENGINE_EARLY_EXIT_EN ends the scan at the first winning direction.
module board_engine
   import board_pkg::*;
#(
   parameter  int N  = 3,
   parameter  int K  = 3,
   localparam int RW = $clog2(N)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           new_game,
   board_engine_if.slave  bus,
   output logic [N*N-1:0] posicaoX,
   output logic [N*N-1:0] posicaoY,
   output logic           turn,
   output logic [1:0]     vencedor,
   output logic           game_over
);

   localparam int IW   = $clog2(N*N);
   localparam int CW   = $clog2(K+1);
   localparam int CNTW = $clog2(N*N+1);

`ifdef BOARD_ENGINE_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   state_t          r_state, w_state;
   logic [N*N-1:0]  r_px, w_px, r_po, w_po;
   logic            r_turn, w_turn;
   result_t         r_res, w_res;
   logic [CNTW-1:0] r_cnt, w_cnt;
   logic [RW-1:0]   r_row, w_row, r_col, w_col;
   dir_t            r_dir, w_dir;
   logic            r_hit, w_hit;
   logic            r_err, w_err;

   logic [IW-1:0]   w_idx;
   logic [N*N-1:0]  w_bit;
   logic            w_bad;
   logic [CW-1:0]   w_run;
   logic            w_win, w_any;

   assign w_idx = IW'(int'(bus.move_row)*N + int'(bus.move_col));
   assign w_bit = {{(N*N-1){1'b0}}, 1'b1} << w_idx;
   assign w_bad = (int'(bus.move_row) >= N) || (int'(bus.move_col) >= N)
                || (|((r_px | r_po) & w_bit));

   line_counter #(.N(N), .K(K)) u_line (
      .i_plane (r_turn ? r_po : r_px),
      .i_row   (r_row),
      .i_col   (r_col),
      .i_dir   (r_dir),
      .o_run   (w_run)
   );

   assign w_win = (w_run == CW'(K));
   assign w_any = r_hit | w_win;

   always_comb begin
      w_state = r_state;
      w_px    = r_px;
      w_po    = r_po;
      w_turn  = r_turn;
      w_res   = r_res;
      w_cnt   = r_cnt;
      w_row   = r_row;
      w_col   = r_col;
      w_dir   = r_dir;
      w_hit   = r_hit;
      w_err   = 1'b0;
      if (new_game) begin
         w_state = ST_IDLE;
         w_px    = '0;
         w_po    = '0;
         w_turn  = 1'b0;
         w_res   = NONE;
         w_cnt   = '0;
         w_dir   = DIR_H;
         w_hit   = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.move_valid) begin
                  if (w_bad) begin
                     w_err = 1'b1;
                  end else begin
                     if (r_turn) w_po = r_po | w_bit;
                     else        w_px = r_px | w_bit;
                     w_cnt   = r_cnt + 1'b1;
                     w_row   = bus.move_row;
                     w_col   = bus.move_col;
                     w_dir   = DIR_H;
                     w_hit   = 1'b0;
                     w_state = ST_CHECK;
                  end
               end
            end
            ST_CHECK: begin
               if ((EARLY && w_win) || r_dir == DIR_A) begin
                  if (w_any) begin
                     w_res   = r_turn ? O_WINS : X_WINS;
                     w_state = ST_DONE;
                  end else if (r_cnt == CNTW'(N*N)) begin
                     w_res   = DRAW;
                     w_state = ST_DONE;
                  end else begin
                     w_turn  = ~r_turn;
                     w_state = ST_IDLE;
                  end
               end else begin
                  w_dir = dir_t'(r_dir + 2'd1);
                  w_hit = w_any;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_px    <= '0;
         r_po    <= '0;
         r_turn  <= 1'b0;
         r_res   <= NONE;
         r_cnt   <= '0;
         r_row   <= '0;
         r_col   <= '0;
         r_dir   <= DIR_H;
         r_hit   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_px    <= w_px;
         r_po    <= w_po;
         r_turn  <= w_turn;
         r_res   <= w_res;
         r_cnt   <= w_cnt;
         r_row   <= w_row;
         r_col   <= w_col;
         r_dir   <= w_dir;
         r_hit   <= w_hit;
         r_err   <= w_err;
      end
   end

   assign bus.move_ready = (r_state == ST_IDLE);
   assign bus.move_err   = r_err;
   assign posicaoX       = r_px;
   assign posicaoY       = r_po;
   assign turn           = r_turn;
   assign vencedor       = r_res;
   assign game_over      = (r_state == ST_DONE);

endmodule
